// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for the shared single-port memory
// Optional MEM_ARB_HOLD_LIMIT_EN: forces a handover after MAX_HOLD consecutive acks under contention.
module mem_arbiter #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DWIDTH-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   hold_hit;

  assign rdata = mem_rdata;

`ifdef MEM_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_hit = (ack0 | ack1) && (hold_cnt_q == HW'(MAX_HOLD - 1));

  // Counts acks within the current grant; any state change restarts the run.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if ((ack0 | ack1) && (hold_cnt_q != HW'(MAX_HOLD))) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? G0 : G1;
        end else if (req0) begin
          state_d = G0;
        end else if (req1) begin
          state_d = G1;
        end
      end
      G0: begin
        if (!req0) begin
          state_d = req1 ? G1 : IDLE;
        end else if (req1 && hold_hit) begin
          state_d = G1;
        end
      end
      G1: begin
        if (!req1) begin
          state_d = req0 ? G0 : IDLE;
        end else if (req0 && hold_hit) begin
          state_d = G0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == G0) begin
        last_d = 1'b0;
      end else if (state_d == G1) begin
        last_d = 1'b1;
      end
    end
  end

  // Output decode; reset suppresses any access so memory is untouched.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      G0: begin
        gnt0      = 1'b1;
        ack0      = req0 & ~rst;
        mem_rd    = req0 & ~rst & ~wr0;
        mem_wr    = req0 & ~rst & wr0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      G1: begin
        gnt1      = 1'b1;
        ack1      = req1 & ~rst;
        mem_rd    = req1 & ~rst & ~wr1;
        mem_wr    = req1 & ~rst & wr1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Contention expectations follow MEM_ARB_HOLD_LIMIT_EN as compiled.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_init;

  logic [DW-1:0] mem [0:31];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: each word preloaded with 8'h80 | address.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h80 | 8'(i);
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic e0;
    rst = 1'b1; mem_init = 1'b1;
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset with both requesting
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      tick;
    end
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("idle_after_rst_gnt0", gnt0, 0);
    tick;

    // First grant: requester 0 wins the tie; turn it into a write
    req1 = 1'b0; wr0 = 1'b1; addr0 = 5'h03; wdata0 = 8'hA5;
    @(negedge clk);
    chk("first_gnt0", gnt0, 1);
    chk("wr_ack0", ack0, 1);
    chk("wr_mem_wr", mem_wr, 1);
    chk("wr_mem_addr", mem_addr, 5'h03);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    tick;
    wr0 = 1'b0;
    @(negedge clk);
    chk("rd_ack0", ack0, 1);
    chk("rd_mem_rd", mem_rd, 1);
    chk("rd_mem_wr", mem_wr, 0);
    chk("rd_rdata", rdata, 8'hA5);
    tick;

    // Re-reset so last=1, then tie test
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("rst2_ack0", ack0, 0);
    tick;
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 5'h01; addr1 = 5'h02;
    @(negedge clk);
    chk("tie1_idle_gnt0", gnt0, 0);
    chk("tie1_idle_gnt1", gnt1, 0);
    tick;
    @(negedge clk);
    chk("tie1_gnt0", gnt0, 1);
    chk("tie1_ack0", ack0, 1);
    chk("tie1_rdata0", rdata, 8'h81);
    tick;
    req0 = 1'b0;
    @(negedge clk);
    chk("tie1_drop_ack0", ack0, 0);
    chk("tie1_drop_gnt1", gnt1, 0);
    tick;
    @(negedge clk);
    chk("tie1_handover_gnt1", gnt1, 1);
    chk("tie1_ack1", ack1, 1);
    chk("tie1_mem_addr1", mem_addr, 5'h02);
    chk("tie1_rdata1", rdata, 8'h82);
    tick;
    req1 = 1'b0;
    @(negedge clk);
    chk("tie1_drop_ack1", ack1, 0);
    tick;
    @(negedge clk);
    chk("tie1_idle_gnt0b", gnt0, 0);
    chk("tie1_idle_gnt1b", gnt1, 0);
    tick;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("tie2_idle_gnt0", gnt0, 0);

    // Second tie, then continuous contention; cycle 1 is the tie grant
    for (int c = 1; c <= 20; c++) begin
      tick;
`ifdef MEM_ARB_HOLD_LIMIT_EN
      e0 = (((c - 1) / MH) % 2) == 0;
`else
      e0 = 1'b1;
`endif
      @(negedge clk);
      chk($sformatf("cont_ack0_c%0d", c), ack0, e0);
      chk($sformatf("cont_ack1_c%0d", c), ack1, !e0);
    end

    // Hand to requester 1, then reset in the middle of its write
    tick;
    req0 = 1'b0;
    tick;
    rst = 1'b1; wr1 = 1'b1; addr1 = 5'h1F; wdata1 = 8'h3C;
    @(negedge clk);
    chk("rstw_gnt1", gnt1, 1);
    chk("rstw_ack1", ack1, 0);
    chk("rstw_mem_wr", mem_wr, 0);
    tick;
    rst = 1'b0; req1 = 1'b0; wr1 = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 5'h1F;
    @(negedge clk);
    chk("rstw_idle_gnt0", gnt0, 0);
    chk("rstw_idle_gnt1", gnt1, 0);
    tick;
    @(negedge clk);
    chk("rstw_rd_ack0", ack0, 1);
    chk("rstw_rd_rdata", rdata, 8'h9F);
    tick;
    req0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
